serial_code_lock: RTL
=====================

SERIAL_CODE_LOCK -- requirements
Module: serial_code_lock

Interface
REQ-001 The block SHALL have parameter CODE_LEN, default 6, giving the code length in bits (legal range 2..32).
REQ-002 The block SHALL have parameter CODE, default 6'b101100, giving the CODE_LEN-bit unlock code, with the MSB received first.
REQ-003 The block SHALL have parameter MAX_TRIES, default 3, giving the consecutive failed frames before lockout (legal range 1..15).
REQ-004 The block SHALL have parameter LOCK_CYCLES, default 16, giving the lockout duration in clk cycles (legal range >=1).
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: synchronous, active-low reset.
REQ-007 The block SHALL have port in, input, 1 bit: the serial code bit.
REQ-008 The block SHALL have port in_valid, input, 1 bit: qualifies `in`; one bit is consumed per cycle while high.
REQ-009 The block SHALL have port frame_clr, input, 1 bit: discards the partial frame in progress.
REQ-010 The block SHALL have port aberta, output, 1 bit: one-cycle pulse marking a correct frame.
REQ-011 The block SHALL have port erro, output, 1 bit: one-cycle pulse marking a wrong frame.
REQ-012 The block SHALL have port bloqueado, output, 1 bit: high while in lockout.
REQ-013 The block SHALL have port tries_left, output, $clog2(MAX_TRIES+1) bits: remaining attempts before lockout.

Function
REQ-014 The FSM SHALL have states COLLECT and LOCKOUT; all outputs SHALL be registered.
REQ-015 In COLLECT, each cycle with in_valid=1 SHALL shift `in` into a CODE_LEN-bit register and increment the bit counter.
REQ-016 Frames SHALL be non-overlapping: after CODE_LEN accepted bits, the counter SHALL return to 0 with no sliding-window match.
REQ-017 On the cycle the CODE_LEN-th bit is accepted, the next cycle SHALL assert exactly one of aberta or erro for exactly one cycle.
REQ-018 Between frames, aberta=erro=0; a partial frame SHALL never produce a pulse.
REQ-019 On a correct frame, the fail counter SHALL clear and tries_left SHALL become MAX_TRIES in the same cycle aberta rises.
REQ-020 On a wrong frame, the fail counter SHALL increment and tries_left SHALL decrement in the same cycle erro rises.
REQ-021 When tries_left reaches 0, the FSM SHALL enter LOCKOUT on that same edge, with bloqueado=1 in the same cycle erro=1.
REQ-022 LOCKOUT SHALL last exactly LOCK_CYCLES cycles.
REQ-023 In LOCKOUT, in_valid and frame_clr SHALL be ignored and no aberta/erro SHALL be produced.
REQ-024 On leaving LOCKOUT, the FSM SHALL enter COLLECT with bit counter 0, shift register 0, tries_left=MAX_TRIES and bloqueado=0.
REQ-025 frame_clr=1 in COLLECT SHALL zero the bit counter next cycle; tries_left SHALL be unchanged.
REQ-026 If frame_clr and in_valid are both 1 in the same cycle, frame_clr SHALL win and the bit SHALL be discarded, even on a would-be final bit.
REQ-027 The block SHALL be idle-tolerant: in_valid=0 gaps of any length SHALL not alter the frame.

Reset
REQ-028 rst=0 at a clk edge SHALL force COLLECT, bit counter 0, shift register 0, fail counter 0, aberta=0, erro=0, bloqueado=0, tries_left=MAX_TRIES.
REQ-029 Reset SHALL take priority over every input, including mid-frame and mid-lockout, and SHALL abort any pending pulse.

Configuration
REQ-030 Macro CODE_LOCK_LOCKOUT_EN defined: the LOCKOUT state, lockout timer and fail counter SHALL exist as specified above.
REQ-031 Macro CODE_LOCK_LOCKOUT_EN undefined: no LOCKOUT state SHALL exist, bloqueado SHALL be tied 0, tries_left SHALL be tied to MAX_TRIES, and aberta/erro behaviour SHALL be unchanged.

Structure
REQ-032 Package code_lock_pkg SHALL hold the state enum (COLLECT, LOCKOUT) and the default constants for CODE_LEN, CODE, MAX_TRIES and LOCK_CYCLES.
REQ-033 Sub-module code_lock_timer SHALL be a down-counter with load/expire outputs sized $clog2(LOCK_CYCLES+1), instantiated only under CODE_LOCK_LOCKOUT_EN.

Verification (defaults)
REQ-034 Drive bits 1,0,1,1,0,0 with in_valid=1 on consecutive cycles -> aberta=1 for one cycle after the sixth bit, erro=0, tries_left=3.
REQ-035 Drive 1,0,1,1,0,1 -> erro pulse and tries_left=2; then drive 101100 -> aberta pulse and tries_left=3.
REQ-036 Drive three wrong frames -> third erro coincides with bloqueado=1; send 101100 during lockout -> no pulse; bloqueado falls after 16 cycles and tries_left=3.
REQ-037 Drive 1,0,1, assert frame_clr, then drive 101100 -> exactly one aberta pulse, aligned to the new frame.
REQ-038 Drive 1,0,1,1 with random in_valid gaps then 0,0 -> aberta pulse; also assert rst=0 mid-frame and mid-lockout -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/code_lock_pkg.sv
// Shared types and default constants for the serial code lock.
package code_lock_pkg;

  typedef enum logic {
    COLLECT = 1'b0,
    LOCKOUT = 1'b1
  } state_t;

  localparam int unsigned DEF_CODE_LEN    = 6;
  localparam logic [31:0] DEF_CODE        = 32'b101100;
  localparam int unsigned DEF_MAX_TRIES   = 3;
  localparam int unsigned DEF_LOCK_CYCLES = 16;

endpackage

// File: rtl/code_lock_timer.sv
// Lockout down-counter: load arms it, expire flags the final counting cycle.
module code_lock_timer
  import code_lock_pkg::*;
#(
  parameter int unsigned LOCK_CYCLES = DEF_LOCK_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic expire
);

  localparam int unsigned W = $clog2(LOCK_CYCLES + 1);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else if (load) begin
      count <= W'(LOCK_CYCLES);
    end else if (en && count != '0) begin
      count <= count - W'(1);
    end
  end

  assign expire = en && (count == W'(1));

endmodule

// File: rtl/serial_code_lock.sv
// Serial code lock: MSB-first non-overlapping frames, registered pulse outputs.
// Lockout after MAX_TRIES wrong frames exists only with CODE_LOCK_LOCKOUT_EN defined.
module serial_code_lock
  import code_lock_pkg::*;
#(
  parameter int unsigned           CODE_LEN    = DEF_CODE_LEN,
  parameter logic [CODE_LEN-1:0]   CODE        = DEF_CODE[CODE_LEN-1:0],
  parameter int unsigned           MAX_TRIES   = DEF_MAX_TRIES,
  parameter int unsigned           LOCK_CYCLES = DEF_LOCK_CYCLES
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in,
  input  logic                           in_valid,
  input  logic                           frame_clr,
  output logic                           aberta,
  output logic                           erro,
  output logic                           bloqueado,
  output logic [$clog2(MAX_TRIES+1)-1:0] tries_left
);

  localparam int unsigned CW = $clog2(CODE_LEN + 1);
  localparam int unsigned TW = $clog2(MAX_TRIES + 1);

  if (CODE_LEN < 2 || CODE_LEN > 32) begin : g_bad_code_len
    $error("serial_code_lock: CODE_LEN out of range 2..32");
  end
  if (MAX_TRIES < 1 || MAX_TRIES > 15) begin : g_bad_max_tries
    $error("serial_code_lock: MAX_TRIES out of range 1..15");
  end
  if (LOCK_CYCLES < 1) begin : g_bad_lock_cycles
    $error("serial_code_lock: LOCK_CYCLES must be at least 1");
  end

  logic [CW-1:0]       cnt, cnt_nx;
  logic [CODE_LEN-1:0] sr, sr_nx, shifted;
  logic                aberta_nx, erro_nx;
  logic                collecting;

  assign shifted = {sr[CODE_LEN-2:0], in};

`ifdef CODE_LOCK_LOCKOUT_EN
  state_t        state, state_nx;
  logic [TW-1:0] fails, fails_nx;
  logic          timer_load, timer_en, timer_expire;

  code_lock_timer #(
    .LOCK_CYCLES(LOCK_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (timer_load),
    .en     (timer_en),
    .expire (timer_expire)
  );

  assign collecting = (state == COLLECT);
`else
  assign collecting = 1'b1;
`endif

  always_comb begin
    cnt_nx    = cnt;
    sr_nx     = sr;
    aberta_nx = 1'b0;
    erro_nx   = 1'b0;
    // frame_clr outranks in_valid, so a clear on the last bit drops the frame
    if (collecting) begin
      if (frame_clr) begin
        cnt_nx = '0;
      end else if (in_valid) begin
        sr_nx = shifted;
        if (cnt == CW'(CODE_LEN - 1)) begin
          cnt_nx    = '0;
          aberta_nx = (shifted == CODE);
          erro_nx   = (shifted != CODE);
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
    end

`ifdef CODE_LOCK_LOCKOUT_EN
    state_nx   = state;
    fails_nx   = fails;
    timer_load = 1'b0;
    timer_en   = 1'b0;
    case (state)
      COLLECT: begin
        if (aberta_nx) begin
          fails_nx = '0;
        end else if (erro_nx) begin
          if (fails == TW'(MAX_TRIES - 1)) begin
            fails_nx   = TW'(MAX_TRIES);
            state_nx   = LOCKOUT;
            timer_load = 1'b1;
          end else begin
            fails_nx = fails + TW'(1);
          end
        end
      end
      LOCKOUT: begin
        timer_en = 1'b1;
        if (timer_expire) begin
          state_nx = COLLECT;
          fails_nx = '0;
          cnt_nx   = '0;
          sr_nx    = '0;
        end
      end
      default: state_nx = COLLECT;
    endcase
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt    <= '0;
      sr     <= '0;
      aberta <= 1'b0;
      erro   <= 1'b0;
`ifdef CODE_LOCK_LOCKOUT_EN
      state      <= COLLECT;
      fails      <= '0;
      bloqueado  <= 1'b0;
      tries_left <= TW'(MAX_TRIES);
`endif
    end else begin
      cnt    <= cnt_nx;
      sr     <= sr_nx;
      aberta <= aberta_nx;
      erro   <= erro_nx;
`ifdef CODE_LOCK_LOCKOUT_EN
      state      <= state_nx;
      fails      <= fails_nx;
      bloqueado  <= (state_nx == LOCKOUT);
      tries_left <= TW'(MAX_TRIES) - fails_nx;
`endif
    end
  end

`ifndef CODE_LOCK_LOCKOUT_EN
  assign bloqueado  = 1'b0;
  assign tries_left = TW'(MAX_TRIES);
`endif

endmodule
